ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the multi-cycle RV32 core: holds the PC, issues one instruction-memory request at a time over a valid/ready handshake, and captures the response. It presents `inst` with its `inst_pc` to the decode stage, where `immgen` and the control decoder consume it. Redirects from the execute/write-back stage retarget the PC and squash any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h8000_0000: first fetch address after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: fetch address, always equal to the PC register.
- `imem_rsp_valid` in 1: response valid for one cycle. No backpressure on this channel.
- `imem_rsp_data` in 32: fetched word.
- `imem_rsp_err` in 1: access fault, qualified by `imem_rsp_valid`.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode consumes the instruction.
- `inst` out 32: instruction word.
- `inst_pc` out 32: address of `inst`.
- `inst_fault` out 1: `inst` is not executable because of an access fault or a misaligned PC.
- `redirect_valid` in 1: one-cycle redirect pulse.
- `redirect_pc` in 32: new PC.

## Operation
- States: IDLE, REQ, WAIT, OUT. There is also a `kill` flag register.
- **IDLE**: entered only on reset. Moves to REQ on the next edge.
- **REQ**:
  - If `pc[1:0]==0`: `imem_req_valid=1`. On `valid&ready`, move to WAIT.
  - If `pc[1:0]!=0`: no request is issued. Latch `inst=0`, `inst_pc=pc`, `inst_fault=1`, and move to OUT.
- **WAIT**:
  - On `imem_rsp_valid` with `kill=0`: latch `inst=rsp_data`, `inst_pc=pc`, `inst_fault=rsp_err`. If `rsp_err=1`, force `inst=0`. Move to OUT.
  - On `imem_rsp_valid` with `kill=1`: discard the response, clear `kill`, move to REQ.
- **OUT**: `inst_valid=1`. On `inst_ready`, set `pc <= pc+4` (mod 2^32) and move to REQ.
- Outputs are Moore: `imem_req_valid` is asserted only in REQ, `inst_valid` only in OUT. `inst`, `inst_pc` and `inst_fault` are registers and hold their value outside OUT.
- `redirect_valid` has priority over every other transition and always sets `pc <= redirect_pc`. Per state:
  - IDLE: stays IDLE for that edge.
  - REQ with no request handshake: stays REQ.
  - REQ with a request handshake in the same cycle: moves to WAIT with `kill=1`.
  - WAIT with no response: stays WAIT with `kill=1`.
  - WAIT with a response in the same cycle: the response is discarded and the state moves to REQ.
  - OUT: the held instruction is dropped, even if `inst_ready` is high, and the state moves to REQ.
- Only one request is ever outstanding. The memory returns exactly one response per accepted request.

## Timing
- Reset values: state=IDLE, `pc=RESET_PC`, `kill=0`, `inst=0`, `inst_pc=0`, `inst_fault=0`. This gives `imem_req_valid=0`, `inst_valid=0`, `imem_req_addr=RESET_PC`.
- After reset release:
  - Edge 1: IDLE→REQ.
  - Cycle 1: request visible.
- Latency, with request accepted at cycle N and response at cycle N+k (k≥1): `inst_valid` rises at cycle N+k+1.
- Peak throughput is one instruction per 3 cycles (REQ, WAIT, OUT, with `ready` and `rsp` immediate).
- Redirect latency: the new address appears on `imem_req_addr` the cycle after the pulse. The request is issued then, or after the squashed response drains.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). The memory is reset by the same `rst_n`, so stale responses cannot occur.

## Structure
- `defines.vh` holds:
  - the `IFU_IDLE`/`IFU_REQ`/`IFU_WAIT`/`IFU_OUT` 2-bit encodings;
  - `RESET_PC_DEFAULT`;
  - `NOP_INST` (32'h0000_0013), reserved for the decode-side flush.
- Single module. No sub-module is warranted: the PC, state register and output latch share their enables.

## Test plan
- **Reset/basic fetch:** with ready=1 and the response one cycle later carrying 32'h0000_0093 → `imem_req_addr=8000_0000` in cycle 1, `inst_valid` in cycle 3 with `inst=0000_0093`, `inst_pc=8000_0000`. The next request is to 8000_0004.
- **Backpressure:** `inst_ready=0` for 5 cycles → `inst`, `inst_pc` and `inst_valid` stay stable, and there is no new request until the ready cycle.
- **Redirect in WAIT:** pulse `redirect_pc=8000_0100` while waiting, response arrives 2 cycles later → the response is discarded, the next request is to 8000_0100, and `inst_valid` never shows the stale word.
- **Simultaneous events:** redirect in the same cycle as a request handshake, and separately in the same cycle as `rsp_valid` → exactly one response is discarded in each case, and the following fetch is to the redirect target.
- **Faults:** `redirect_pc=8000_0102` → no memory request is made, and the output has `inst_fault=1`, `inst=0`, `inst_pc=8000_0102`. Separately, a response with `rsp_err=1` → `inst_fault=1`, `inst=0`.
- **Async reset mid-WAIT:** assert `rst_n=0` → state, `pc` and outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    // Canonical addi x0,x0,0; decode substitutes it when flushing.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/ifu.sv
// ifu: PC holder issuing one instruction-memory request at a time and
// presenting the fetched word to decode; redirects squash in-flight fetches.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    ifu_state_t  state, state_next;
    logic [31:0] pc, pc_next;
    logic        kill, kill_next;
    logic        aligned, req_fire, cap_misalign, cap_rsp;

    assign aligned      = pc[1:0] == 2'b00;
    assign req_fire     = imem_req_valid & imem_req_ready;
    assign cap_misalign = (state == IFU_REQ) & ~aligned & ~redirect_valid;
    assign cap_rsp      = (state == IFU_WAIT) & imem_rsp_valid & ~kill & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IFU_IDLE;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IFU_IDLE: state_next = redirect_valid ? IFU_IDLE : IFU_REQ;
            IFU_REQ:  state_next = req_fire ? IFU_WAIT : cap_misalign ? IFU_OUT : IFU_REQ;
            IFU_WAIT: state_next = !imem_rsp_valid ? IFU_WAIT :
                                   (kill || redirect_valid) ? IFU_REQ : IFU_OUT;
            IFU_OUT:  state_next = (redirect_valid || inst_ready) ? IFU_REQ : IFU_OUT;
            default:  state_next = IFU_IDLE;
        endcase
    end

    // A redirect that lands while a request is accepted or outstanding
    // leaves exactly one response to drop.
    always_comb begin
        kill_next = (state == IFU_REQ)  ? redirect_valid & req_fire :
                    (state == IFU_WAIT) ? ~imem_rsp_valid & (kill | redirect_valid) : 1'b0;
        pc_next   = redirect_valid ? redirect_pc :
                    (state == IFU_OUT && inst_ready) ? pc + 32'd4 : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else if (cap_misalign) begin
            inst       <= '0;
            inst_pc    <= pc;
            inst_fault <= 1'b1;
        end else if (cap_rsp) begin
            inst       <= imem_rsp_err ? 32'h0 : imem_rsp_data;
            inst_pc    <= pc;
            inst_fault <= imem_rsp_err;
        end
    end

    always_comb begin
        imem_req_valid = (state == IFU_REQ) & aligned;
        imem_req_addr  = pc;
        inst_valid     = state == IFU_OUT;
    end

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: randomized scoreboard bench for ifu against a fetch-stream reference model.
module tb_ifu;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        inst_fault;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    ifu #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .imem_rsp_err(imem_rsp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0, miscompares = 0, consumed = 0;
    bit          active = 0, rnd = 0, no_redir = 0;
    logic [31:0] model_pc = RPC;
    bit          mem_pend = 0, squash = 0;
    logic [31:0] mem_addr = '0, rsp_addr = '0;
    int          mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a - RPC) * 32'h0101_0101 + 32'h0000_0093;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:2] == 5'd13;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic [31:0] word, input logic fault);
        exp_t e;
        e.pc = pc;
        e.word = word;
        e.fault = fault;
        q.push_back(e);
    endtask

    // Monitor: every consumed instruction must match the head of the queue.
    always @(negedge clk) begin
        if (active) begin
            if (inst_valid && q.size() == 0) flag("unexpected_inst");
            if (redirect_valid) q.delete();
            else if (inst_valid && inst_ready && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("inst", inst, e.word);
                check("inst_pc", inst_pc, e.pc);
                check("inst_fault", {31'b0, inst_fault}, {31'b0, e.fault});
                consumed++;
            end
        end
    end

    task automatic step(input int c);
        @(posedge clk);
        #1;
        if (rnd) begin
            redirect_valid = !no_redir && ($urandom_range(0, 99) < 6);
            redirect_pc = RPC + 32'($urandom_range(0, 63)) * 32'd4 +
                          (($urandom_range(0, 6) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            imem_req_ready = $urandom_range(0, 3) != 0;
            inst_ready = $urandom_range(0, 2) != 0;
        end else begin
            redirect_valid = 1'b0;
            imem_req_ready = 1'b1;
            inst_ready = !(c >= 3 && c < 8);
        end
        if (mem_pend && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mem_word(mem_addr);
            imem_rsp_err = mem_err(mem_addr);
            rsp_addr = mem_addr;
            mem_pend = 0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = $urandom;
            imem_rsp_err = 1'($urandom_range(0, 1));
            if (mem_pend) mem_cnt--;
        end
        @(negedge clk);
        #2;
        if (imem_req_valid && inst_valid) flag("req_during_out");
        if (imem_rsp_valid && !squash && !redirect_valid)
            expect_out(rsp_addr, mem_err(rsp_addr) ? 32'h0 : mem_word(rsp_addr), mem_err(rsp_addr));
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, model_pc);
            if (mem_pend) flag("two_outstanding");
            mem_pend = 1;
            mem_addr = imem_req_addr;
            mem_cnt = rnd ? int'($urandom_range(0, 2)) : 0;
            squash = redirect_valid;
        end else if (mem_pend && redirect_valid) squash = 1;
        if (redirect_valid) begin
            model_pc = redirect_pc;
            if (model_pc[1:0] != 2'b00) expect_out(model_pc, 32'h0, 1'b1);
        end else if (inst_valid && inst_ready) begin
            model_pc = model_pc + 32'd4;
            if (model_pc[1:0] != 2'b00) expect_out(model_pc, 32'h0, 1'b1);
        end
        if (c == 1) begin
            check("c1_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check("c1_req_addr", imem_req_addr, RPC);
        end
        if (c == 3) begin
            check("c3_inst_valid", {31'b0, inst_valid}, 32'd1);
            check("c3_inst", inst, 32'h0000_0093);
            check("c3_inst_pc", inst_pc, RPC);
        end
        if (c == 5) check("c5_no_req", {31'b0, imem_req_valid}, 32'd0);
        if (c == 7) begin
            check("c7_held_valid", {31'b0, inst_valid}, 32'd1);
            check("c7_held_pc", inst_pc, RPC);
        end
        if (c == 9) check("c9_next_addr", imem_req_addr, RPC + 32'd4);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RPC);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_inst_fault"}, {31'b0, inst_fault}, 32'd0);
    endtask

    initial begin
        bit found;
        #12;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        active = 1;
        for (int c = 1; c <= 20; c++) step(c);
        rnd = 1;
        for (int c = 21; c <= 3000; c++) step(c);
        no_redir = 1;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step(0);
            found = mem_pend;
        end
        if (!found) flag("wait_timeout");
        check("progress", {31'b0, consumed > 100}, 32'd1);
        @(posedge clk);
        #2;
        active = 0;
        rst_n = 1'b0;
        #1;
        check_reset("async");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
